adpll_sar_ctrl: RTL
===================

// Module: adpll_sar_ctrl
// PURPOSE
//  Next-generation ADPLL loop controller; drives the DCO tuning words CTW/FTW from filtered PFD UP/DN.
//  Two phases: SAR binary search on CTW (coarse), then bang-bang tracking on FTW (fine).
//  Adds lock/unlock detection, automatic re-acquisition on fine-range exhaustion, and a relock request.
//  Sits between digital_filter and dco, in the ref_clk domain; replaces the fixed-step controller.
// PARAMETERS
//  CTW_W        8   coarse tuning word width
//  FTW_W        8   fine tuning word width
//  SETTLE       16  ref_clk cycles per SAR bit (DCO settle + UP/DN vote window), >=1
//  LOCK_CYCLES  32  consecutive balanced cycles in FINE needed to declare lock, >=1
//  UNLOCK_CYCLES 4  consecutive unbalanced cycles in LOCKED needed to drop lock, >=1
// PORTS
//  ref_clk      in   1      loop clock (reference clock)
//  reset        in   1      synchronous, active-high reset
//  enable       in   1      1 = run loop; 0 = return to IDLE
//  relock       in   1      single-cycle pulse: restart coarse acquisition
//  up           in   1      filtered PFD UP (feedback lags reference: DCO too slow)
//  dn           in   1      filtered PFD DN (feedback leads reference: DCO too fast)
//  ctw          out  CTW_W  coarse tuning word to DCO; larger = faster
//  ftw          out  FTW_W  fine tuning word to DCO; larger = faster
//  coarse_done  out  1      1 while in FINE or LOCKED
//  locked       out  1      1 while in LOCKED
//  state        out  2      IDLE=0, COARSE=1, FINE=2, LOCKED=3
// BEHAVIOUR
//  One clock: ref_clk. Reset synchronous, active-high. All outputs are registered.
//  Reset: state=IDLE, ctw=1<<(CTW_W-1), ftw=1<<(FTW_W-1) (midscale), coarse_done=0, locked=0.
//  Priority per edge: reset > !enable > relock > normal FSM.
//  !enable in any state: next edge -> IDLE; ctw/ftw reload midscale; locked=0; coarse_done=0.
//  IDLE: enable=1 -> COARSE. Load bit index k=CTW_W-1, ctw=midscale, ftw=midscale.
//   Clear vote counters and window counter.
//  COARSE: SAR search. Trial value has bit k set.
//   - Every cycle, count up-only (up&!dn) and dn-only (dn&!up) samples.
//     Counter width clog2(SETTLE+1).
//   - On the SETTLE-th sample: if dn_cnt > up_cnt, clear bit k; otherwise keep it (tie keeps).
//     Then, if k>0, set bit k-1, decrement k, and clear the counters in the same edge.
//   - After bit 0 is decided -> FINE, coarse_done=1. Coarse time is exactly CTW_W*SETTLE cycles.
//   - ftw is held at midscale throughout COARSE.
//  FINE and LOCKED: every cycle, one step.
//   - up-only: ftw+1. dn-only: ftw-1. Both or neither: hold.
//   - Rail: an up-only cycle at ftw=max, or a dn-only cycle at ftw=0, forces COARSE restart.
//     That edge sets state=COARSE, ftw=midscale, ctw=midscale, k=CTW_W-1, locked=0, coarse_done=0.
//     ftw never wraps.
//  Lock detect (FINE): bal_cnt counts consecutive cycles with up==dn; any unbalanced cycle clears it.
//   - At the edge where bal_cnt reaches LOCK_CYCLES: -> LOCKED, locked=1.
//  Unlock (LOCKED): unb_cnt counts consecutive unbalanced cycles; any balanced cycle clears it.
//   - At the edge where unb_cnt reaches UNLOCK_CYCLES: -> FINE, locked=0, bal_cnt=0.
//   - ftw keeps tracking throughout.
//  relock=1 in COARSE/FINE/LOCKED: same as a rail restart; the SAR begins again from bit CTW_W-1.
//   - relock in IDLE is ignored.
//  Entering FINE from COARSE or from LOCKED clears bal_cnt and unb_cnt.
// TESTING
//  1. enable=1, up=1, dn=0 held -> after 8*16=128 COARSE cycles: ctw=0xFF, coarse_done=1, state=FINE, ftw=0x80.
//  2. enable=1, dn=1, up=0 held in COARSE -> ctw=0x00 at coarse_done.
//     Alternate-bit vote pattern -> ctw matches the reference SAR model.
//  3. In FINE, up=dn=0 for 32 cycles -> locked=1 on the 32nd edge.
//     An up pulse at cycle 20 restarts the count (lock at cycle 52).
//  4. In LOCKED, up-only for 4 cycles -> locked=0, state=FINE, ftw advanced by 4.
//     3 up-only cycles then 1 balanced cycle -> stays LOCKED.
//  5. In FINE, ftw=0x80, up-only held -> ftw=0xFF after 127 cycles.
//     Next edge -> state=COARSE, ctw=ftw=0x80, locked=0.
//  6. Mid-COARSE enable=0 -> IDLE next edge, ctw=0x80; relock pulse in LOCKED -> COARSE, k=7.
//     reset asserted mid-FINE -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/adpll_sar_ctrl.sv
// -----------------------------------------------------------------------------
// adpll_sar_ctrl
//   ADPLL loop controller. It sets the DCO coarse tuning word (ctw) by a SAR
//   binary search on the filtered PFD up/dn votes. It then tracks the fine
//   tuning word (ftw) one LSB per cycle by bang-bang steps. It declares and
//   drops lock from runs of balanced/unbalanced cycles. If ftw would run past
//   either rail, or when relock is pulsed, coarse acquisition starts again.
//
// Ports
//   ref_clk      in   1      loop clock
//   reset        in   1      synchronous, active-high reset
//   enable       in   1      1 = run loop, 0 = park in IDLE
//   relock       in   1      pulse: restart coarse acquisition (ignored in IDLE)
//   up           in   1      PFD UP, DCO too slow
//   dn           in   1      PFD DN, DCO too fast
//   ctw          out  CTW_W  coarse tuning word (larger = faster)
//   ftw          out  FTW_W  fine tuning word (larger = faster)
//   coarse_done  out  1      high in FINE or LOCKED
//   locked       out  1      high in LOCKED
//   state        out  2      IDLE=0, COARSE=1, FINE=2, LOCKED=3
// -----------------------------------------------------------------------------
module adpll_sar_ctrl #(
  parameter int CTW_W         = 8,
  parameter int FTW_W         = 8,
  parameter int SETTLE        = 16,
  parameter int LOCK_CYCLES   = 32,
  parameter int UNLOCK_CYCLES = 4
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             relock,
  input  logic             up,
  input  logic             dn,
  output logic [CTW_W-1:0] ctw,
  output logic [FTW_W-1:0] ftw,
  output logic             coarse_done,
  output logic             locked,
  output logic [1:0]       state
);

  localparam int KW = (CTW_W > 1) ? $clog2(CTW_W) : 1;
  localparam int VW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(LOCK_CYCLES + 1);
  localparam int UW = $clog2(UNLOCK_CYCLES + 1);

  localparam logic [CTW_W-1:0] CTW_MID = CTW_W'(1) << (CTW_W - 1);
  localparam logic [FTW_W-1:0] FTW_MID = FTW_W'(1) << (FTW_W - 1);
  localparam logic [FTW_W-1:0] FTW_MAX = {FTW_W{1'b1}};
  localparam logic [KW-1:0]    K_TOP   = KW'(CTW_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COARSE = 2'd1,
    S_FINE   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t           state_q;
  logic [CTW_W-1:0] ctw_q;
  logic [FTW_W-1:0] ftw_q;
  logic [KW-1:0]    k_q;
  logic [VW-1:0]    up_cnt_q, dn_cnt_q, win_q;
  logic [BW-1:0]    bal_q;
  logic [UW-1:0]    unb_q;
  logic             coarse_done_q, locked_q;

  logic             up_only, dn_only, balanced;
  logic [VW-1:0]    up_tot, dn_tot;
  logic             win_last, sar_keep;
  logic [CTW_W-1:0] k_bit, ctw_sar_d;
  logic [FTW_W-1:0] ftw_step_d;
  logic             ftw_rail, tracking, restart;

  assign up_only  = up & ~dn;
  assign dn_only  = dn & ~up;
  assign balanced = (up == dn);

  // Vote totals including the current cycle's sample, so the decision on
  // the SETTLE-th sample sees the full window.
  assign up_tot   = up_cnt_q + VW'(up_only);
  assign dn_tot   = dn_cnt_q + VW'(dn_only);
  assign win_last = (win_q == VW'(SETTLE - 1));
  assign sar_keep = ~(dn_tot > up_tot);   // tie keeps the trial bit

  // Resolve bit k and set the next trial bit (k_bit>>1 is zero once k=0).
  assign k_bit     = CTW_W'(1) << k_q;
  assign ctw_sar_d = (ctw_q & ~k_bit) | (sar_keep ? k_bit : '0) | (k_bit >> 1);

  assign ftw_step_d = up_only ? (ftw_q + FTW_W'(1)) :
                      dn_only ? (ftw_q - FTW_W'(1)) : ftw_q;
  assign ftw_rail   = (up_only && (ftw_q == FTW_MAX)) || (dn_only && (ftw_q == '0));
  assign tracking   = (state_q == S_FINE) || (state_q == S_LOCKED);

  // A fresh coarse search starts on leaving IDLE, on relock, or on a rail hit.
  assign restart = (state_q == S_IDLE) || (relock && (state_q != S_IDLE)) ||
                   (tracking && ftw_rail);

  // Loop controller FSM; every output is a register.
  always_ff @(posedge ref_clk) begin
    if (reset || !enable) begin
      state_q       <= S_IDLE;
      ctw_q         <= CTW_MID;
      ftw_q         <= FTW_MID;
      k_q           <= K_TOP;
      up_cnt_q      <= '0;
      dn_cnt_q      <= '0;
      win_q         <= '0;
      bal_q         <= '0;
      unb_q         <= '0;
      coarse_done_q <= 1'b0;
      locked_q      <= 1'b0;
    end else if (restart) begin
      state_q       <= S_COARSE;
      ctw_q         <= CTW_MID;
      ftw_q         <= FTW_MID;
      k_q           <= K_TOP;
      up_cnt_q      <= '0;
      dn_cnt_q      <= '0;
      win_q         <= '0;
      bal_q         <= '0;
      unb_q         <= '0;
      coarse_done_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      case (state_q)
        S_COARSE: begin
          if (win_last) begin
            ctw_q    <= ctw_sar_d;
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
            win_q    <= '0;
            if (k_q != KW'(0)) begin
              k_q <= k_q - KW'(1);
            end else begin
              state_q       <= S_FINE;
              coarse_done_q <= 1'b1;
              bal_q         <= '0;
              unb_q         <= '0;
            end
          end else begin
            up_cnt_q <= up_tot;
            dn_cnt_q <= dn_tot;
            win_q    <= win_q + VW'(1);
          end
        end
        S_FINE: begin
          ftw_q <= ftw_step_d;
          if (!balanced) begin
            bal_q <= '0;
          end else if (bal_q == BW'(LOCK_CYCLES - 1)) begin
            state_q  <= S_LOCKED;
            locked_q <= 1'b1;
            bal_q    <= '0;
            unb_q    <= '0;
          end else begin
            bal_q <= bal_q + BW'(1);
          end
        end
        S_LOCKED: begin
          ftw_q <= ftw_step_d;
          if (balanced) begin
            unb_q <= '0;
          end else if (unb_q == UW'(UNLOCK_CYCLES - 1)) begin
            state_q  <= S_FINE;
            locked_q <= 1'b0;
            bal_q    <= '0;
            unb_q    <= '0;
          end else begin
            unb_q <= unb_q + UW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctw         = ctw_q;
  assign ftw         = ftw_q;
  assign coarse_done = coarse_done_q;
  assign locked      = locked_q;
  assign state       = state_q;

endmodule
